result_packer: RTL



---
 rtl/rheed_pkg.sv | 24 ++
 rtl/axis_beat_reg.sv | 42 ++++
 rtl/result_packer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rheed_pkg.sv
// Shared types and constants for the outbound result packing path.
package rheed_pkg;

  localparam int AXIS_DATA_W = 256;
  localparam int AXIS_KEEP_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // Byte-enable mask covering the low used_lanes lanes of a beat.
  function automatic logic [AXIS_KEEP_W-1:0] keep_mask(input int used_lanes,
                                                       input int lane_bytes);
    logic [AXIS_KEEP_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < AXIS_KEEP_W; i++) begin
      mask[i] = (i < used_lanes * lane_bytes);
    end
    return mask;
  endfunction

endpackage

// File: rtl/axis_beat_reg.sv
// Single-entry register holding one outbound 256-bit beat; a new beat may
// load in the same cycle the held beat is accepted downstream.
module axis_beat_reg
  import rheed_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [AXIS_DATA_W-1:0] load_data,
  input  logic [AXIS_KEEP_W-1:0] load_keep,
  input  logic                   load_last,
  input  logic                   tready,
  output logic                   tvalid,
  output logic [AXIS_DATA_W-1:0] tdata,
  output logic [AXIS_KEEP_W-1:0] tkeep,
  output logic                   tlast,
  output logic                   fire,
  output logic                   busy
);

  assign fire = tvalid && tready;
  assign busy = tvalid && !tready;

  // The producer only asserts load when the register is empty or draining,
  // so a pending beat is never overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tkeep  <= '0;
      tlast  <= 1'b0;
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= load_data;
      tkeep  <= load_keep;
      tlast  <= load_last;
    end else if (fire) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/result_packer.sv
// Packs a single-pixel AXI Stream into 256-bit beats, one pixel per lane,
// marking the frame end with tlast and a byte-masked final beat.
module result_packer
  import rheed_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int LANE_WIDTH      = 16,
  parameter int OUT_ROWS        = 20,
  parameter int OUT_COLS        = 20
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       s_axis_resetn,
  input  logic                       ap_start,
  output logic                       ap_idle,
  output logic                       ap_done,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [AXIS_DATA_W-1:0]     m_axis_tdata,
  output logic [AXIS_KEEP_W-1:0]     m_axis_tkeep,
  output logic                       m_axis_tlast
);

  localparam int N          = AXIS_DATA_W / LANE_WIDTH;
  localparam int F          = OUT_ROWS * OUT_COLS;
  localparam int PIX_W      = (F > 1) ? $clog2(F) : 1;
  localparam int LANE_W     = (N > 1) ? $clog2(N) : 1;
  localparam int LANE_BYTES = LANE_WIDTH / 8;
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(F - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(N - 1);

  generate
    if (PIXEL_BIT_WIDTH > LANE_WIDTH) begin : g_bad_pixel_width
      $error("result_packer: PIXEL_BIT_WIDTH must not exceed LANE_WIDTH");
    end
    if ((AXIS_DATA_W % LANE_WIDTH) != 0 || (LANE_WIDTH % 8) != 0) begin : g_bad_lane_width
      $error("result_packer: LANE_WIDTH must be a whole number of bytes dividing 256");
    end
  endgenerate

  state_t                 state;
  logic [PIX_W-1:0]       pix_cnt;
  logic [LANE_W-1:0]      lane_cnt;
  logic [AXIS_DATA_W-1:0] acc;
  logic [AXIS_DATA_W-1:0] beat_data;
  logic [AXIS_KEEP_W-1:0] beat_keep;
  logic                   rst_int;
  logic                   last_pixel;
  logic                   closing;
  logic                   accept;
  logic                   out_busy;
  logic                   beat_fire;

  assign rst_int       = srst || !s_axis_resetn;
  assign last_pixel    = (pix_cnt == PIX_LAST);
  assign closing       = (lane_cnt == LANE_LAST) || last_pixel;
  assign s_axis_tready = (state == RUN) && !(closing && out_busy);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign ap_idle       = (state == IDLE);
  assign ap_done       = (state == DRAIN) && beat_fire && m_axis_tlast && !rst_int;

  // Accumulator with the incoming pixel merged in; lanes above the current
  // one are still zero because the accumulator is cleared after each beat.
  always_comb begin
    beat_data = acc;
    beat_data[lane_cnt * LANE_WIDTH +: LANE_WIDTH] = LANE_WIDTH'(s_axis_tdata);
    beat_keep = keep_mask(int'(lane_cnt) + 1, LANE_BYTES);
  end

  always_ff @(posedge clk) begin
    if (rst_int) begin
      state    <= IDLE;
      pix_cnt  <= '0;
      lane_cnt <= '0;
      acc      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            state    <= RUN;
            pix_cnt  <= '0;
            lane_cnt <= '0;
            acc      <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            pix_cnt <= last_pixel ? '0 : pix_cnt + 1'b1;
            if (closing) begin
              lane_cnt <= '0;
              acc      <= '0;
            end else begin
              lane_cnt <= lane_cnt + 1'b1;
              acc      <= beat_data;
            end
            if (last_pixel) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (beat_fire && m_axis_tlast) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  axis_beat_reg u_beat_reg (
    .clk       (clk),
    .rst       (rst_int),
    .load      (accept && closing),
    .load_data (beat_data),
    .load_keep (beat_keep),
    .load_last (last_pixel),
    .tready    (m_axis_tready),
    .tvalid    (m_axis_tvalid),
    .tdata     (m_axis_tdata),
    .tkeep     (m_axis_tkeep),
    .tlast     (m_axis_tlast),
    .fire      (beat_fire),
    .busy      (out_busy)
  );

endmodule
